// File: rtl/painter_pkg.sv
// Shared mode encodings and field widths for the LED panel painter.
package painter_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned RGB_W  = 3;

    localparam logic [MODE_W-1:0] MODE_GRID     = 2'd0;
    localparam logic [MODE_W-1:0] MODE_CHECKER  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_GRADIENT = 2'd2;
    localparam logic [MODE_W-1:0] MODE_BLANK    = 2'd3;

    localparam logic [RGB_W-1:0] RGB_CHECK_ON  = 3'b110;
    localparam logic [RGB_W-1:0] RGB_CHECK_OFF = 3'b001;

endpackage

// File: rtl/painter_delay.sv
// Synchronous-reset shift register: DEPTH stages of WIDTH bits.
module painter_delay #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("painter_delay: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/painter_pipe.sv
// Multi-mode pixel painter: pattern from (x, y, frame, subframe) delivered DELAY clocks later.
// Mode changes are only taken on a frame boundary so a frame never mixes patterns.
module painter_pipe
    import painter_pkg::*;
#(
    parameter int unsigned DELAY         = 3,
    parameter int unsigned X_BITS        = 6,
    parameter int unsigned Y_BITS        = 6,
    parameter int unsigned FRAME_BITS    = 10,
    parameter int unsigned SUBFRAME_BITS = 8,
    parameter int unsigned CELL_LOG2     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [FRAME_BITS-1:0]    frame,
    input  logic [SUBFRAME_BITS-1:0] subframe,
    input  logic [X_BITS-1:0]        x,
    input  logic [Y_BITS-1:0]        y,
    input  logic [MODE_W-1:0]        mode_sel,
    output logic [MODE_W-1:0]        mode,
    output logic [RGB_W-1:0]         rgb
);

    if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
        $error("painter_pipe: DELAY must be in 1..16");
    end
    if (FRAME_BITS < SUBFRAME_BITS) begin : g_bad_frame
        $error("painter_pipe: FRAME_BITS must be >= SUBFRAME_BITS");
    end
    if (SUBFRAME_BITS < X_BITS || SUBFRAME_BITS < Y_BITS) begin : g_bad_subframe
        $error("painter_pipe: SUBFRAME_BITS must be >= X_BITS and >= Y_BITS");
    end
    if (CELL_LOG2 >= X_BITS || CELL_LOG2 >= Y_BITS) begin : g_bad_cell
        $error("painter_pipe: CELL_LOG2 must be < X_BITS and < Y_BITS");
    end

    localparam logic [X_BITS-1:0] X_MAX = '1;
    localparam logic [Y_BITS-1:0] Y_MAX = '1;
    localparam logic [X_BITS-1:0] X_ONE = 1;
    localparam logic [Y_BITS-1:0] Y_ONE = 1;

    logic [FRAME_BITS-1:0] frame_q;
    logic                  boundary;
    logic [MODE_W-1:0]     mode_eff;

    assign boundary = (frame != frame_q);
    assign mode_eff = boundary ? mode_sel : mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
            mode    <= MODE_GRID;
        end else begin
            frame_q <= frame;
            mode    <= mode_eff;
        end
    end

    logic                     grid_r, grid_g, grid_b;
    logic [X_BITS-1:0]        cx;
    logic                     check_c;
    logic [SUBFRAME_BITS-1:0] ir, ig, ib;
    logic [RGB_W-1:0]         pix;

    // A value is a nonzero power of two when clearing its lowest set bit leaves zero.
    assign grid_r = (x != '0) && ((x & (x - X_ONE)) == '0);
    assign grid_g = (y != '0) && ((y & (y - Y_ONE)) == '0);
    assign grid_b = (x == '0) || (y == '0) || (x == X_MAX) || (y == Y_MAX);

    assign cx      = x + frame[X_BITS-1:0];
    assign check_c = cx[CELL_LOG2] ^ y[CELL_LOG2];

    // Scale coordinates up to the full PWM range so the gradient spans all bit-planes.
    assign ir = SUBFRAME_BITS'(x) << (SUBFRAME_BITS - X_BITS);
    assign ig = SUBFRAME_BITS'(y) << (SUBFRAME_BITS - Y_BITS);
    assign ib = frame[SUBFRAME_BITS-1:0];

    always_comb begin
        pix = '0;
        unique case (mode_eff)
            MODE_GRID:     pix = {grid_b, grid_g, grid_r};
            MODE_CHECKER:  pix = check_c ? RGB_CHECK_ON : RGB_CHECK_OFF;
            MODE_GRADIENT: pix = {ib > subframe, ig > subframe, ir > subframe};
            MODE_BLANK:    pix = '0;
        endcase
    end

    logic [RGB_W-1:0] pix_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix;
        end
    end

    if (DELAY == 1) begin : g_no_delay
        assign rgb = pix_q;
    end else begin : g_delay
        painter_delay #(
            .WIDTH(RGB_W),
            .DEPTH(DELAY - 1)
        ) u_delay (
            .clk  (clk),
            .reset(reset),
            .din  (pix_q),
            .dout (rgb)
        );
    end

endmodule
